// File: rtl/mul_pkg.sv
// Shared constants for the sequential shift-add multiplier: operand width,
// iteration counter sizing and FSM state encodings.
package mul_pkg;

    // Operand width; the datapath and the ripple adder are built for 32 only.
    localparam int MUL_W = 32;

    // Iteration counter holds 0..MUL_W, so it needs log2(MUL_W)+1 bits.
    localparam int CNT_W = $clog2(MUL_W) + 1;

    // Counter value seen in the last CALC cycle (before it increments).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_W - 1);

    // FSM encodings; 2'b11 is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/add1.sv
// 32-bit ripple-carry adder: sum/c_out = a + b + c_in.
module add1 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    // Carry ripples bit by bit from c_in up to c_out.
    always_comb begin
        logic c;
        sum = '0;
        c   = c_in;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        c_out = c;
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned multiplier: 32 shift-add steps through one ripple
// adder, producing a 64-bit product split into prod_hi/prod_lo.
//
// Handshake: start is sampled only while idle (busy=0 and done=0); a start
// seen in that cycle is accepted and a/b are captured on the same edge.
// Starts during CALC or DONE are dropped, never queued. done pulses for
// exactly one cycle and the product registers hold until the next
// completion or reset. All outputs come straight from flops.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] prod_hi,
    output logic [W-1:0] prod_lo,
    output logic [1:0]   dbg_state
);

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     m_q, m_d;
    logic [W-1:0]     q_q, q_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;

    logic [W-1:0]     addend;
    logic [W-1:0]     sum;
    logic             c_out;

    // Add the multiplicand only when the current multiplier LSB is set.
    always_comb begin
        addend = q_q[0] ? m_q : '0;
    end

    add1 u_add (
        .a     (acc_q),
        .b     (addend),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    // Next-state and datapath: capture on start, shift-add in CALC, latch
    // the product on the edge that enters DONE.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // Carry-out becomes the new ACC MSB; the bit shifted out of
                // ACC enters the top of Q, which ends up as the low half.
                acc_d = {c_out, sum[W-1:1]};
                q_d   = {sum[0], q_q[W-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    hi_d    = {c_out, sum[W-1:1]};
                    lo_d    = {sum[0], q_q[W-1:1]};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign prod_hi   = hi_q;
    assign prod_lo   = lo_q;
    assign dbg_state = state_q;

endmodule
